// File: rtl/dac_tx_ctrl_if.sv
// Sample-stream and FIFO write-port bundle for dac_tx_ctrl.
// master = the controller, slave = host stream source plus FIFO.
interface dac_tx_ctrl_if;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        data_we;
    logic [31:0] data_in;
    logic [15:0] fifo_data_cnt;
    logic        fifo_full;
    logic        fifo_empty;

    modport master (
        input  s_valid, s_data, fifo_data_cnt, fifo_full, fifo_empty,
        output s_ready, data_we, data_in
    );

    modport slave (
        output s_valid, s_data, fifo_data_cnt, fifo_full, fifo_empty,
        input  s_ready, data_we, data_in
    );
endinterface

// File: rtl/dac_tx_ctrl.sv
// DAC transmit FIFO write sequencer: zero-fill while idle, host or ramp data in bursts.
// Optional ramp source is built only when DAC_TX_CTRL_TONE_EN is defined.
module dac_tx_ctrl #(
    parameter logic [15:0] IDLE_LEVEL = 16'd512,
    parameter logic [15:0] HIGH_LEVEL = 16'd30720
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [31:0]        burst_len,
    input  logic               pattern_sel,
    dac_tx_ctrl_if.master      bus,
    output logic               busy,
    output logic               done,
    output logic               underrun,
    input  logic               underrun_clr,
    output logic [15:0]        underrun_cnt
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [31:0] remaining;
    logic        empty_q;
    logic        room;
    logic        zfill;
    logic        tone;
    logic        accept;
    logic        wr;
    logic        ev;
    logic [31:0] wr_data;

    assign room  = (bus.fifo_data_cnt < HIGH_LEVEL) && !bus.fifo_full;
    assign zfill = (bus.fifo_data_cnt < IDLE_LEVEL) && !bus.fifo_full;

`ifdef DAC_TX_CTRL_TONE_EN
    logic [15:0] ramp;

    assign tone    = pattern_sel;
    assign wr_data = tone ? {ramp, ~ramp} : bus.s_data;

    always_ff @(posedge clk) begin
        if (reset)
            ramp <= 16'd0;
        else if (state == IDLE && start && !abort)
            ramp <= 16'd0;
        else if (wr && tone)
            ramp <= ramp + 16'd1;
    end
`else
    logic unused_pattern_sel;

    assign unused_pattern_sel = pattern_sel;
    assign tone               = 1'b0;
    assign wr_data            = bus.s_data;
`endif

    assign bus.s_ready = (state == RUN) && room && !abort && !tone;
    assign accept      = bus.s_valid && bus.s_ready;
    // Ramp source writes on its own whenever there is room; host writes need a handshake.
    assign wr          = tone ? ((state == RUN) && room && !abort) : accept;
    assign ev          = (state == RUN) && bus.fifo_empty && !empty_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            remaining   <= 32'd0;
            bus.data_we <= 1'b0;
            bus.data_in <= 32'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    bus.data_we <= zfill;
                    if (zfill)
                        bus.data_in <= 32'd0;
                    if (start && !abort) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        remaining <= burst_len;
                    end
                end
                RUN: begin
                    bus.data_we <= wr;
                    if (wr)
                        bus.data_in <= wr_data;
                    // remaining stays 0 for the whole of a continuous burst
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (wr && remaining != 32'd0) begin
                        remaining <= remaining - 32'd1;
                        if (remaining == 32'd1) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            empty_q      <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= 16'd0;
        end else begin
            empty_q <= bus.fifo_empty;
            if (ev) begin
                underrun <= 1'b1;
                if (underrun_clr)
                    underrun_cnt <= 16'd1;
                else if (underrun_cnt != 16'hFFFF)
                    underrun_cnt <= underrun_cnt + 16'd1;
            end else if (underrun_clr) begin
                underrun     <= 1'b0;
                underrun_cnt <= 16'd0;
            end
        end
    end

endmodule

// File: tb/tb_dac_tx_ctrl.sv
// Directed bench for dac_tx_ctrl: expected FIFO writes go into a queue and a
// negedge monitor pops and compares every write the DUT issues.
module tb_dac_tx_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [31:0] burst_len;
    logic        pattern_sel;
    logic        busy;
    logic        done;
    logic        underrun;
    logic        underrun_clr;
    logic [15:0] underrun_cnt;

    dac_tx_ctrl_if bus ();

    dac_tx_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .burst_len    (burst_len),
        .pattern_sel  (pattern_sel),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .underrun     (underrun),
        .underrun_clr (underrun_clr),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        dn;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic dn);
        exp_t e;
        e.d  = d;
        e.dn = dn;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.data_we) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write got data %h done %b want no write", bus.data_in, done);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("wr_data", bus.data_in, e.d);
                    chk("wr_done", {31'd0, done}, {31'd0, e.dn});
                end
            end else if (done) begin
                checks++;
                errors++;
                $display("FAIL stray_done got done 1 without write want 0");
            end
        end
    end

    initial begin
        reset             = 1'b1;
        start             = 1'b0;
        abort             = 1'b0;
        burst_len         = 32'd0;
        pattern_sel       = 1'b0;
        underrun_clr      = 1'b0;
        bus.s_valid       = 1'b0;
        bus.s_data        = 32'd0;
        bus.fifo_data_cnt = 16'd1000;
        bus.fifo_full     = 1'b0;
        bus.fifo_empty    = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data_we", {31'd0, bus.data_we}, 32'd0);
        chk("rst_data_in", bus.data_in, 32'd0);
        chk("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
        chk("rst_underrun_cnt", {16'd0, underrun_cnt}, 32'd0);
        step();
        reset = 1'b0;
        step();

        // idle zero-fill below IDLE_LEVEL, stops at the watermark
        bus.fifo_data_cnt = 16'd100;
        for (int i = 0; i < 5; i++) begin
            push(32'd0, 1'b0);
            step();
        end
        bus.fifo_data_cnt = 16'd512;
        step();
        chk("zfill_stop", {31'd0, bus.data_we}, 32'd0);
        bus.fifo_data_cnt = 16'd1000;
        step();

        // four-sample host burst
        burst_len = 32'd4;
        start     = 1'b1;
        step();
        start = 1'b0;
        chk("burst_busy_rise", {31'd0, busy}, 32'd1);
        bus.s_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.s_data = i;
            push(i, i == 4);
            step();
        end
        chk("burst_busy_fall", {31'd0, busy}, 32'd0);
        bus.s_data = 32'd5;
        step();
        step();
        bus.s_valid = 1'b0;

        // high watermark and fifo_full backstop
        burst_len = 32'd3;
        start     = 1'b1;
        step();
        start             = 1'b0;
        bus.fifo_data_cnt = 16'd30720;
        bus.s_valid       = 1'b1;
        bus.s_data        = 32'hA1;
        #1;
        chk("high_ready", {31'd0, bus.s_ready}, 32'd0);
        step();
        step();
        bus.fifo_data_cnt = 16'd30719;
        #1;
        chk("below_high_ready", {31'd0, bus.s_ready}, 32'd1);
        push(32'hA1, 1'b0);
        step();
        bus.fifo_full = 1'b1;
        bus.s_data    = 32'hA2;
        #1;
        chk("full_ready", {31'd0, bus.s_ready}, 32'd0);
        step();
        bus.fifo_full = 1'b0;
        push(32'hA2, 1'b0);
        step();
        bus.s_data = 32'hA3;
        push(32'hA3, 1'b1);
        step();
        bus.s_valid       = 1'b0;
        bus.fifo_data_cnt = 16'd1000;
        chk("wm_busy_fall", {31'd0, busy}, 32'd0);
        step();

        // continuous burst ended by abort
        burst_len = 32'd0;
        start     = 1'b1;
        step();
        start       = 1'b0;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.s_data = 32'h100 + i;
            push(32'h100 + i, 1'b0);
            step();
        end
        chk("cont_busy", {31'd0, busy}, 32'd1);
        abort      = 1'b1;
        bus.s_data = 32'h999;
        #1;
        chk("abort_ready", {31'd0, bus.s_ready}, 32'd0);
        step();
        abort       = 1'b0;
        bus.s_valid = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        bus.fifo_data_cnt = 16'd100;
        for (int i = 0; i < 2; i++) begin
            push(32'd0, 1'b0);
            step();
        end
        bus.fifo_data_cnt = 16'd1000;
        step();

        // underrun edges in RUN, clear coincident with a new edge, plain clear
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.fifo_empty = 1'b1;
            step();
            bus.fifo_empty = 1'b0;
            step();
        end
        chk("ur_flag", {31'd0, underrun}, 32'd1);
        chk("ur_cnt2", {16'd0, underrun_cnt}, 32'd2);
        bus.fifo_empty = 1'b1;
        underrun_clr   = 1'b1;
        step();
        underrun_clr   = 1'b0;
        bus.fifo_empty = 1'b0;
        chk("ur_clr_ev_flag", {31'd0, underrun}, 32'd1);
        chk("ur_clr_ev_cnt", {16'd0, underrun_cnt}, 32'd1);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        chk("ur_clr_flag", {31'd0, underrun}, 32'd0);
        chk("ur_clr_cnt", {16'd0, underrun_cnt}, 32'd0);
        abort = 1'b1;
        step();
        abort          = 1'b0;
        bus.fifo_empty = 1'b1;
        step();
        step();
        bus.fifo_empty = 1'b0;
        chk("idle_empty_flag", {31'd0, underrun}, 32'd0);
        chk("idle_empty_cnt", {16'd0, underrun_cnt}, 32'd0);

`ifdef DAC_TX_CTRL_TONE_EN
        // ramp source: host stream ignored, s_ready held low
        pattern_sel = 1'b1;
        burst_len   = 32'd3;
        bus.s_valid = 1'b1;
        bus.s_data  = 32'hDEAD_BEEF;
        start       = 1'b1;
        step();
        start = 1'b0;
        push(32'h0000_FFFF, 1'b0);
        push(32'h0001_FFFE, 1'b0);
        push(32'h0002_FFFD, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("tone_ready", {31'd0, bus.s_ready}, 32'd0);
            step();
        end
        chk("tone_busy_fall", {31'd0, busy}, 32'd0);
        bus.s_valid = 1'b0;
        pattern_sel = 1'b0;
`endif

        repeat (3) step();
        chk("queue_drained", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
